// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths and the parity accumulate helper for the router register stage
// Contents:
//   DATA_WIDTH_DEF : default byte width of the packet datapath
//   ADDR_WIDTH_DEF : default number of header LSBs carrying the destination address
//   parity_acc()   : one step of the byte-wise XOR parity accumulation
package router_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 2;

  // One accumulation step; folding every header and payload byte through this
  // yields the parity byte a well-formed packet carries at its tail.
  function automatic logic [DATA_WIDTH_DEF-1:0] parity_acc(
    input logic [DATA_WIDTH_DEF-1:0] acc,
    input logic [DATA_WIDTH_DEF-1:0] data_byte
  );
    return acc ^ data_byte;
  endfunction

endpackage

// File: rtl/router_reg.sv
// rtl/router_reg.sv - router datapath register stage: header capture, payload register, full-byte hold, parity check
// Ports:
//   clock, resetn      : clock and synchronous active-low reset
//   pkt_valid          : source packet valid, drops on the parity byte
//   data_in            : packet byte from the source
//   fifo_full          : selected destination FIFO is full
//   detect_add .. rst_int_reg : one-hot state qualifiers from the router control FSM
//   parity_done        : parity byte has been received
//   low_pkt_valid      : pkt_valid dropped while loading data
//   err                : parity mismatch for the last packet
//   dout               : registered byte towards the destination FIFO
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] hdr_byte_q, hdr_byte_d;
  logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
  logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
  logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
  logic                  parity_done_q, parity_done_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  err_q, err_d;

  logic new_header;
  assign new_header = detect_add && pkt_valid;

  always_comb begin
    dout_d          = dout_q;
    hdr_byte_d      = hdr_byte_q;
    full_byte_d     = full_byte_q;
    int_parity_d    = int_parity_q;
    pkt_parity_d    = pkt_parity_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;

    if (new_header) begin
      hdr_byte_d = data_in;
    end

    // Output byte: a byte arriving while the FIFO is full is parked in
    // full_byte and replayed in LOAD_AFTER_FULL; dout holds meanwhile.
    if (lfd_state) begin
      dout_d = hdr_byte_q;
    end else if (ld_state && !fifo_full) begin
      dout_d = data_in;
    end else if (ld_state && fifo_full) begin
      full_byte_d = data_in;
    end else if (laf_state) begin
      dout_d = full_byte_q;
    end

    if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end

    // A parity byte parked by a full FIFO only completes once it is replayed.
    if (detect_add) begin
      parity_done_d = 1'b0;
    end else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_pkt_valid_q && !parity_done_q)) begin
      parity_done_d = 1'b1;
    end

    // Payload bytes are folded in when first seen in LOAD_DATA, even if the
    // FIFO is full, so the replay in LOAD_AFTER_FULL must not fold again.
    if (detect_add) begin
      int_parity_d = '0;
    end else if (lfd_state) begin
      int_parity_d = parity_acc(int_parity_q, hdr_byte_q);
    end else if (ld_state && pkt_valid && !full_state) begin
      int_parity_d = parity_acc(int_parity_q, data_in);
    end

    if (new_header) begin
      pkt_parity_d = '0;
    end else if (ld_state && !pkt_valid) begin
      pkt_parity_d = data_in;
    end

    // err survives into DECODE_ADDRESS and only drops when a new header lands.
    if (new_header) begin
      err_d = 1'b0;
    end else if (parity_done_q) begin
      err_d = (int_parity_q != pkt_parity_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dout_q          <= '0;
      hdr_byte_q      <= '0;
      full_byte_q     <= '0;
      int_parity_q    <= '0;
      pkt_parity_q    <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      hdr_byte_q      <= hdr_byte_d;
      full_byte_q     <= full_byte_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  // The FSM drives exactly one qualifier at a time; overlap is undefined here.
  always_ff @(posedge clock) begin
    if (resetn) begin
      assert ($onehot0({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg})
              && (ADDR_WIDTH <= DATA_WIDTH));
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule
